// File: rtl/sobel_filter.sv
// Three-stage Sobel gradient magnitude with thresholded edge flag.
// Frame-border windows are blanked, and syncs are delayed to match the data path.
module sobel_filter #(
   parameter int WIDTH  = 10,
   parameter int HEIGHT = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  pixel_in1,
   input  logic [7:0]  pixel_in2,
   input  logic [7:0]  pixel_in3,
   input  logic [7:0]  pixel_in4,
   input  logic [7:0]  pixel_in5,
   input  logic [7:0]  pixel_in6,
   input  logic [7:0]  pixel_in7,
   input  logic [7:0]  pixel_in8,
   input  logic [7:0]  pixel_in9,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        de_in,
   input  logic [10:0] threshold,
   output logic [7:0]  pixel_out,
   output logic        edge_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        de_out
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

   logic [CW-1:0] col;
   logic [RW-1:0] row;

   logic [10:0]        gx_pos, gx_neg, gy_pos, gy_neg;
   logic signed [10:0] gx0, gy0;
   logic               border0;

   logic signed [10:0] gx1, gy1;
   logic               hs1, vs1, de1, bd1;

   logic [9:0]         abs_gx, abs_gy;
   logic [9:0]         ax2, ay2;
   logic               hs2, vs2, de2, bd2;

   logic [10:0]        mag;
   logic               blank;

   // The centre pixel p5 has zero weight in both kernels.
   assign gx_pos = {3'b0, pixel_in3} + {2'b0, pixel_in6, 1'b0} + {3'b0, pixel_in9};
   assign gx_neg = {3'b0, pixel_in1} + {2'b0, pixel_in4, 1'b0} + {3'b0, pixel_in7};
   assign gy_pos = {3'b0, pixel_in7} + {2'b0, pixel_in8, 1'b0} + {3'b0, pixel_in9};
   assign gy_neg = {3'b0, pixel_in1} + {2'b0, pixel_in2, 1'b0} + {3'b0, pixel_in3};
   assign gx0    = signed'(gx_pos - gx_neg);
   assign gy0    = signed'(gy_pos - gy_neg);

   // A window that arrives together with vsync sits at col 0, row 0.
   assign border0 = de_in & (vsync_in | (col == '0) | (col == COL_LAST) |
                             (row == '0) | (row == ROW_LAST));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col <= '0;
         row <= '0;
      end else if (vsync_in) begin
         col <= '0;
         row <= '0;
      end else if (de_in) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gx1 <= '0;
         gy1 <= '0;
         hs1 <= 1'b0;
         vs1 <= 1'b0;
         de1 <= 1'b0;
         bd1 <= 1'b0;
      end else begin
         gx1 <= gx0;
         gy1 <= gy0;
         hs1 <= hsync_in;
         vs1 <= vsync_in;
         de1 <= de_in;
         bd1 <= border0;
      end
   end

   // |G| never exceeds 1020, so the low ten bits of the two's complement suffice.
   assign abs_gx = gx1[10] ? 10'(~gx1[9:0] + 10'd1) : gx1[9:0];
   assign abs_gy = gy1[10] ? 10'(~gy1[9:0] + 10'd1) : gy1[9:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ax2 <= '0;
         ay2 <= '0;
         hs2 <= 1'b0;
         vs2 <= 1'b0;
         de2 <= 1'b0;
         bd2 <= 1'b0;
      end else begin
         ax2 <= abs_gx;
         ay2 <= abs_gy;
         hs2 <= hs1;
         vs2 <= vs1;
         de2 <= de1;
         bd2 <= bd1;
      end
   end

   assign mag   = {1'b0, ax2} + {1'b0, ay2};
   assign blank = ~de2 | bd2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pixel_out <= '0;
         edge_out  <= 1'b0;
         hsync_out <= 1'b0;
         vsync_out <= 1'b0;
         de_out    <= 1'b0;
      end else begin
         pixel_out <= blank ? 8'd0 : ((|mag[10:8]) ? 8'hFF : mag[7:0]);
         edge_out  <= ~blank & (mag >= threshold);
         hsync_out <= hs2;
         vsync_out <= vs2;
         de_out    <= de2;
      end
   end

endmodule

// File: doc/sobel_filter.md
# sobel_filter

Pipelined Sobel gradient stage directly downstream of `line_buffer`. Consumes the 3x3 window (`pixel_in1..9`) plus the delayed `hsync`/`vsync`/`de` produced alongside it. Outputs an 8-bit saturated |Gx|+|Gy| edge magnitude and a thresholded edge flag, with syncs re-aligned to the 3-cycle pipeline latency. Frame-border pixels are forced to zero.

## Interface
- `WIDTH`, 10: active pixels per line (window-centre columns).
- `HEIGHT`, 5: active lines per frame.
- `clk`  in  1  rising-edge clock, one window per cycle.
- `rst`  in  1  asynchronous, active-low reset (`rst`=0 resets).
- `pixel_in1`..`pixel_in9`  in  8 each  window, row-major: 1 = top-left, 5 = centre, 9 = bottom-right; unsigned.
- `hsync_in`, `vsync_in`, `de_in`  in  1 each  syncs aligned with the window; active-high.
- `threshold`  in  11  unsigned edge threshold; sampled every cycle at stage 3.
- `pixel_out`  out  8  saturated magnitude.
- `edge`  out  1  1 when the unsaturated magnitude is >= `threshold`.
- `hsync_out`, `vsync_out`, `de_out`  out  1 each  input syncs delayed 3 cycles.

## Operation
- Kernel arithmetic, signed 11-bit:
  - Gx = (p3 + 2·p6 + p9) − (p1 + 2·p4 + p7)
  - Gy = (p7 + 2·p8 + p9) − (p1 + 2·p2 + p3)
  - Range of each: ±1020.
- Stage 1 registers Gx, Gy.
- Stage 2 registers |Gx| and |Gy|, unsigned 10-bit, max 1020.
- Stage 3 computes mag = |Gx|+|Gy|, unsigned 11-bit, max 2040, never overflows.
  - `pixel_out` = (mag > 255) ? 255 : mag[7:0].
  - `edge` = (mag >= `threshold`).
- Position counters (`col`, `row`) track the window centre at stage 0:
  - `vsync_in`=1 forces `col`=0, `row`=0. This takes priority over `de_in`.
  - `de_in`=1 increments `col`. At `col`==WIDTH−1 it wraps to 0 and `row` increments.
  - `row` wraps from HEIGHT−1 to 0.
  - `de_in`=0 holds both counters.
- Border flag = `de_in` & (`col`==0 | `col`==WIDTH−1 | `row`==0 | `row`==HEIGHT−1). It is registered and pipelined with the data.
- Output gating at stage 3: if the delayed de = 0 or the delayed border flag = 1, then `pixel_out`=0 and `edge`=0. Arithmetic still runs.
- No back-pressure. One result per cycle, no stalls.

## Timing
- Latency: exactly 3 clk cycles from inputs to all outputs. Data, border flag and syncs use identical delay taps.
- Reset (`rst`=0, async):
  - All pipeline registers, outputs, `col` and `row` clear to 0 immediately, without waiting for a clock edge.
  - Outputs remain 0 until 3 rising edges after release.
- Reset release mid-frame: counters restart at 0, so the frame is misaligned until the next `vsync_in`. This is acceptable and must not hang.
- `vsync_in` and `de_in` high in the same cycle: the counters clear, and that cycle's window is treated as `col`=0, `row`=0, so it is a border pixel.
- Threshold change: takes effect on the first stage-3 result computed after the change. No internal latching.
- Throughput: 1 window/clk, continuous streaming with `de_in` held high across lines permitted.

## Test plan
- Flat window, all pixels = 100, interior position, `de_in`=1 → 3 cycles later `pixel_out`=0, `edge`=1 only if `threshold`=0.
- Vertical step: p1,p4,p7=0 and p3,p6,p9=255, others 128, interior position, `threshold`=500 → Gx=1020, Gy=0, `pixel_out`=255 (saturated), `edge`=1.
- Small gradient: p3,p6,p9=10 and others 0, interior position:
  - Gx=40, Gy=0, `pixel_out`=40.
  - `threshold`=40 → `edge`=1.
  - `threshold`=41 → `edge`=0.
- Border suppression: WIDTH=10, HEIGHT=5, pulse `vsync_in` then stream 50 windows of the vertical-step pattern → `pixel_out`=255 only for `row` 1..3 with `col` 1..8 (24 pixels); all others 0. `de_out`/`hsync_out` track inputs shifted exactly 3 cycles.
- `de_in`=0 gap mid-line: counters hold, outputs 0 for the gap (delayed 3 cycles), and the next pixel resumes at the correct `col`.
- Assert `rst`=0 asynchronously between clock edges mid-stream → all outputs 0 before the next edge. After release, the first non-zero output appears no earlier than the 3rd rising edge.
